// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one unified memory between instruction
// fetch and data access, with data priority and a bounded fetch-starvation streak.
//
// state  | meaning
// IDLE   | no access in flight; requests sampled here
// BUSY_I | fetch access issued to memory, waiting for mem_ack_i
// BUSY_D | data access issued to memory, waiting for mem_ack_i
// RESP_I | one-cycle if_ack_o pulse
// RESP_D | one-cycle dm_ack_o pulse
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,

    output logic              stall_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int              SW         = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0]   STREAK_LIM = SW'(STREAK_MAX);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nx;
    logic          grant_i;
    logic          grant_d;
    logic          busy_done;

    assign busy_done = ((state == BUSY_I) || (state == BUSY_D)) && mem_ack_i;

    always_comb begin
        state_nx  = state;
        streak_nx = streak;
        grant_i   = 1'b0;
        grant_d   = 1'b0;

        case (state)
            IDLE: begin
                // Data wins unless a waiting fetch has already been passed over STREAK_MAX times.
                if (dm_req_i && !(if_req_i && (streak == STREAK_LIM))) begin
                    grant_d  = 1'b1;
                    state_nx = BUSY_D;
                end else if (if_req_i) begin
                    grant_i  = 1'b1;
                    state_nx = BUSY_I;
                end
            end
            BUSY_I: if (mem_ack_i) state_nx = RESP_I;
            BUSY_D: if (mem_ack_i) state_nx = RESP_D;
            RESP_I: state_nx = IDLE;
            RESP_D: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (grant_i) begin
            streak_nx = '0;
        end else if (grant_d) begin
            if (!if_req_i) begin
                streak_nx = '0;
            end else if (streak != STREAK_LIM) begin
                streak_nx = streak + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nx;
            streak <= streak_nx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_data_o   <= '0;
            dm_rdata_o  <= '0;
        end else begin
            if (grant_d) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= dm_we_i;
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
            end else if (grant_i) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= if_addr_i;
                mem_wdata_o <= '0;
            end else if (busy_done) begin
                mem_req_o <= 1'b0;
                mem_we_o  <= 1'b0;
            end

            if (busy_done && (state == BUSY_I)) begin
                if_data_o <= mem_rdata_i;
            end
            // Writes leave the last read data untouched.
            if (busy_done && (state == BUSY_D) && !mem_we_o) begin
                dm_rdata_o <= mem_rdata_i;
            end
        end
    end

    assign if_ack_o = (state == RESP_I);
    assign dm_ack_o = (state == RESP_D);
    assign stall_o  = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory model answers
// the arbiter, and each step compares outputs against hand-computed values.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_data;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    logic        model_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [31:0] model_rdata = '0;
    int          lat = 1;
    int          cnt = 0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    logic [31:0] exp_grant [10] = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200,
                                    32'h300, 32'h300, 32'h300, 32'h300, 32'h200};

    assign mem_ack   = model_ack | spur_ack;
    assign mem_rdata = model_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_data_o   (if_data),
        .if_ack_o    (if_ack),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_rdata_o  (dm_rdata),
        .dm_ack_o    (dm_ack),
        .stall_o     (stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (wr_valid && (a == wr_addr)) return wr_data;
        if (a == 32'h40) return 32'h8C22_0004;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory: acks in the lat-th cycle that mem_req is seen high.
    always @(posedge clk) begin
        #1;
        if (rst || !mem_req) begin
            cnt       = 0;
            model_ack = 1'b0;
        end else if (model_ack) begin
            model_ack = 1'b0;
            cnt       = 0;
        end else begin
            cnt = cnt + 1;
            if (cnt >= lat) begin
                model_ack = 1'b1;
                if (mem_we) begin
                    wr_valid = 1'b1;
                    wr_addr  = mem_addr;
                    wr_data  = mem_wdata;
                end else begin
                    model_rdata = mem_word(mem_addr);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(if_ack || dm_ack) && (n < 30));
        if (!(if_ack || dm_ack)) n = -1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && (n < 30));
        if (!mem_req) n = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_if_ack", {31'b0, if_ack}, 32'd0);
        check("rst_dm_ack", {31'b0, dm_ack}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single fetch, L = 1
        lat = 1;
        if_addr = 32'h40;
        if_req = 1'b1;
        #1;
        check("f1_stall_idle", {31'b0, stall}, 32'd1);
        check("f1_req_idle", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        check("f1_mem_req", {31'b0, mem_req}, 32'd1);
        check("f1_mem_addr", mem_addr, 32'h40);
        check("f1_mem_we", {31'b0, mem_we}, 32'd0);
        check("f1_ack_early", {31'b0, if_ack}, 32'd0);
        check("f1_stall_busy", {31'b0, stall}, 32'd1);
        @(negedge clk);
        check("f1_if_ack", {31'b0, if_ack}, 32'd1);
        check("f1_if_data", if_data, 32'h8C22_0004);
        check("f1_stall_ack", {31'b0, stall}, 32'd0);
        check("f1_req_drop", {31'b0, mem_req}, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        check("f1_ack_once", {31'b0, if_ack}, 32'd0);
        check("f1_data_hold", if_data, 32'h8C22_0004);

        // data write then read, L = 3
        lat = 3;
        dm_addr = 32'h100;
        dm_wdata = 32'hDEAD_BEEF;
        dm_we = 1'b1;
        dm_req = 1'b1;
        @(negedge clk);
        check("wr_mem_we", {31'b0, mem_we}, 32'd1);
        check("wr_mem_addr", mem_addr, 32'h100);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        wait_ack(n);
        check("wr_latency", 32'(n), 32'd3);
        check("wr_dm_ack", {31'b0, dm_ack}, 32'd1);
        check("wr_rdata_kept", dm_rdata, 32'd0);
        dm_we = 1'b0;
        dm_wdata = '0;
        wait_ack(n);
        check("rd_latency", 32'(n), 32'd5);
        check("rd_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        dm_req = 1'b0;
        @(negedge clk);

        // both requesters held: D,D,D,D,I repeating
        lat = 1;
        if_addr = 32'h200;
        dm_addr = 32'h300;
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_req(n);
            check("grant_addr", mem_addr, exp_grant[k]);
            wait_ack(n);
            check("grant_ack_wait", 32'(n), 32'd1);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);

        // reset during BUSY_D with the memory ack still pending
        lat = 3;
        dm_addr = 32'h300;
        dm_req = 1'b1;
        wait_req(n);
        check("rs_busy", 32'(n), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rs_mem_req", {31'b0, mem_req}, 32'd0);
        check("rs_mem_we", {31'b0, mem_we}, 32'd0);
        check("rs_mem_addr", mem_addr, 32'd0);
        check("rs_dm_ack", {31'b0, dm_ack}, 32'd0);
        check("rs_if_data", if_data, 32'd0);
        check("rs_dm_rdata", dm_rdata, 32'd0);
        check("rs_stall", {31'b0, stall}, 32'd1);
        dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // spurious memory ack while idle
        spur_ack = 1'b1;
        @(negedge clk);
        check("sp_dm_ack", {31'b0, dm_ack}, 32'd0);
        check("sp_if_ack", {31'b0, if_ack}, 32'd0);
        check("sp_stall", {31'b0, stall}, 32'd0);
        spur_ack = 1'b0;
        @(negedge clk);
        check("sp_dm_ack2", {31'b0, dm_ack}, 32'd0);
        check("sp_if_ack2", {31'b0, if_ack}, 32'd0);
        check("sp_mem_req", {31'b0, mem_req}, 32'd0);

        // first request after reset
        lat = 1;
        if_addr = 32'h40;
        if_req = 1'b1;
        wait_ack(n);
        check("pr_latency", 32'(n), 32'd2);
        check("pr_if_data", if_data, 32'h8C22_0004);
        if_req = 1'b0;
        @(negedge clk);

        // fetch held across two addresses
        lat = 2;
        if_addr = 32'h0;
        if_req = 1'b1;
        wait_ack(n);
        check("ff_latency0", 32'(n), 32'd3);
        check("ff_data0", if_data, 32'hC0DE_0000);
        if_addr = 32'h4;
        wait_req(n);
        check("ff_req_wait", 32'(n), 32'd2);
        check("ff_addr1", mem_addr, 32'h4);
        check("ff_data_hold", if_data, 32'hC0DE_0000);
        wait_ack(n);
        check("ff_latency1", 32'(n), 32'd2);
        check("ff_data1", if_data, 32'hC0DE_0004);
        if_req = 1'b0;
        @(negedge clk);
        check("end_stall", {31'b0, stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
